cpa_nibble_seq: RTL



---
 rtl/cpa_nibble_seq_if.sv | 46 ++++
 rtl/cpa_nibble_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cpa_nibble_seq_if.sv
// ---------------------------------------------------------------------------
// cpa_nibble_seq_if : host-side request/result bus of the nibble sequencer.
// Optional sub/ovf signals exist only when CPA_SEQ_SUB_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface cpa_nibble_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c_out;
`ifdef CPA_SEQ_SUB_EN
  logic         sub;
  logic         ovf;
`endif

  modport master (
    output start, a, b, c_in,
`ifdef CPA_SEQ_SUB_EN
    output sub,
    input  ovf,
`endif
    input  busy, done, s, c_out
  );

  modport slave (
    input  start, a, b, c_in,
`ifdef CPA_SEQ_SUB_EN
    input  sub,
    output ovf,
`endif
    output busy, done, s, c_out
  );

endinterface

`default_nettype wire

// File: rtl/cpa_nibble_seq.sv
// ---------------------------------------------------------------------------
// cpa_nibble_seq : steps an external 4-bit CPA through 4*NIBBLES-bit operands,
// LS nibble first. Macro CPA_SEQ_SUB_EN adds subtract (sub) and overflow (ovf).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpa_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  wire logic       clk,
  input  wire logic       rst,
  cpa_nibble_seq_if.slave bus,
  output logic [3:0]      o_cpa_a,
  output logic [3:0]      o_cpa_b,
  output logic            o_cpa_cin,
  input  wire logic [3:0] i_cpa_s,
  input  wire logic       i_cpa_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] C_K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [KW-1:0] r_k;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;
  logic [W-1:0]  r_s;
  logic          r_cout;
  logic          r_busy;
  logic          r_done;
  logic          w_accept;
  logic          w_last;
  logic [W-1:0]  w_b_in;
  logic          w_cin_in;

  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_k == C_K_LAST);

`ifdef CPA_SEQ_SUB_EN
  logic r_ovf;
  // Two's-complement subtract: invert B and the incoming carry at latch time.
  assign w_b_in   = bus.sub ? ~bus.b    : bus.b;
  assign w_cin_in = bus.sub ? ~bus.c_in : bus.c_in;
  assign bus.ovf  = r_ovf;
`else
  assign w_b_in   = bus.b;
  assign w_cin_in = bus.c_in;
`endif

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.s     = r_s;
  assign bus.c_out = r_cout;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_cpa_a   = 4'h0;
    o_cpa_b   = 4'h0;
    o_cpa_cin = 1'b0;
    if (r_state == S_RUN) begin
      o_cpa_a   = r_a[{r_k, 2'b00} +: 4];
      o_cpa_b   = r_b[{r_k, 2'b00} +: 4];
      o_cpa_cin = r_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef CPA_SEQ_SUB_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
      if (w_accept) begin
        r_a     <= bus.a;
        r_b     <= w_b_in;
        r_carry <= w_cin_in;
        r_k     <= '0;
      end else if (r_state == S_RUN) begin
        r_s[{r_k, 2'b00} +: 4] <= i_cpa_s;
        r_carry                <= i_cpa_cout;
        r_k                    <= w_last ? '0 : r_k + KW'(1);
        if (w_last) begin
          r_cout <= i_cpa_cout;
`ifdef CPA_SEQ_SUB_EN
          // The top nibble's sum bit is the result sign, captured on this same edge.
          r_ovf  <= (r_a[W-1] == r_b[W-1]) && (i_cpa_s[3] != r_a[W-1]);
`endif
        end
      end
    end
  end

endmodule

`default_nettype wire
